// File: rtl/parity_counter_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parity_counter_seq_if : word-in / result-out valid-ready bundle  (rev 1.0)
// ---------------------------------------------------------------------------
interface parity_counter_seq_if #(
  parameter int DATA_W = 7
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W:0]   out_data;
  logic              out_bit;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_bit
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_bit
  );
endinterface
`default_nettype wire

// File: rtl/parity_counter_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parity_counter_seq : bit-serial majority/parity bit inserter  (rev 1.0)
// ---------------------------------------------------------------------------
module parity_counter_seq #(
  parameter int DATA_W  = 7,
  parameter int INS_POS = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  parity_counter_seq_if.slave bus,
  output logic               busy,
  output logic [CNT_W-1:0]   word_cnt
);
  localparam int ONES_W = $clog2(DATA_W + 1);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          mode_q;
  logic [ONES_W-1:0]   ones;
  logic [IDX_W-1:0]    idx;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_bit_q;
  logic [DATA_W:0]     out_data_q;
  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [ONES_W-1:0]   ones_final;
  logic [ONES_W:0]     ones_x2;
  logic                zeros_win;
  logic                ins_bit;
  logic [DATA_W:0]     ins_word;

  // zeros > ones  <=>  2*ones < DATA_W, which avoids a subtraction
  always_comb begin
    ones_final = ones + ONES_W'(data_q[idx]);
    ones_x2    = {ones_final, 1'b0};
    zeros_win  = (ones_x2 < (ONES_W + 1)'(DATA_W));
    ins_bit    = 1'b0;
    unique case (mode_q)
      2'b00:   ins_bit = zeros_win;
      2'b01:   ins_bit = ~zeros_win;
      2'b10:   ins_bit = ones_final[0];
      2'b11:   ins_bit = ~ones_final[0];
      default: ins_bit = 1'b0;
    endcase
  end

  for (genvar i = 0; i <= DATA_W; i++) begin : g_ins
    if (i < INS_POS) begin : g_low
      assign ins_word[i] = data_q[i];
    end else if (i == INS_POS) begin : g_bit
      assign ins_word[i] = ins_bit;
    end else begin : g_high
      assign ins_word[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_q      <= '0;
      mode_q      <= 2'b00;
      ones        <= '0;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            mode_q     <= bus.in_mode;
            ones       <= '0;
            idx        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= COUNT;
          end
        end
        COUNT: begin
          ones <= ones_final;
          idx  <= idx + IDX_W'(1);
          if (idx == IDX_W'(DATA_W - 1)) begin
            out_data_q  <= ins_word;
            out_bit_q   <= ins_bit;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            cnt_q       <= cnt_q + CNT_W'(1);
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_bit   = out_bit_q;
  assign busy          = busy_q;
  assign word_cnt      = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_parity_counter_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_parity_counter_seq : directed vectors for parity_counter_seq  (rev 1.0)
// ---------------------------------------------------------------------------
module tb_parity_counter_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  parity_counter_seq_if #(.DATA_W(7)) bus_a ();
  logic       busy_a;
  logic [7:0] cnt_a;
  parity_counter_seq #(.DATA_W(7), .INS_POS(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .busy(busy_a), .word_cnt(cnt_a)
  );

  // Wide-word, MSB-insert, short-counter variant
  parity_counter_seq_if #(.DATA_W(8)) bus_b ();
  logic       busy_b;
  logic [3:0] cnt_b;
  parity_counter_seq #(.DATA_W(8), .INS_POS(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .busy(busy_b), .word_cnt(cnt_b)
  );

  typedef struct {
    logic [6:0] data;
    logic [1:0] mode;
    logic [7:0] exp_data;
    logic       exp_bit;
  } vec_t;

  vec_t vecs[12];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [6:0] d, input logic [1:0] m, input bit toggle);
    int lat;
    @(negedge clk);
    check("in_ready_idle", 32'(bus_a.in_ready), 1);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_mode  = m;
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = ~d;
    lat = 0;
    while (bus_a.out_valid !== 1'b1 && lat < 20) begin
      if (toggle) bus_a.in_mode = ~bus_a.in_mode;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 7);
  endtask

  task automatic finish_a();
    logic [7:0] prev;
    prev = cnt_a;
    bus_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_a.out_ready = 1'b0;
    check("out_valid_drop", 32'(bus_a.out_valid), 0);
    check("in_ready_back", 32'(bus_a.in_ready), 1);
    check("word_cnt_inc", 32'(cnt_a), 32'(8'(prev + 8'd1)));
  endtask

  initial begin
    vecs[0]  = '{7'h03, 2'b00, 8'h13, 1'b1};
    vecs[1]  = '{7'h03, 2'b01, 8'h03, 1'b0};
    vecs[2]  = '{7'h7F, 2'b00, 8'hEF, 1'b0};
    vecs[3]  = '{7'h7F, 2'b01, 8'hFF, 1'b1};
    vecs[4]  = '{7'h55, 2'b10, 8'hA5, 1'b0};
    vecs[5]  = '{7'h55, 2'b11, 8'hB5, 1'b1};
    vecs[6]  = '{7'h00, 2'b00, 8'h10, 1'b1};
    vecs[7]  = '{7'h00, 2'b10, 8'h00, 1'b0};
    vecs[8]  = '{7'h0F, 2'b00, 8'h0F, 1'b0};
    vecs[9]  = '{7'h0F, 2'b01, 8'h1F, 1'b1};
    vecs[10] = '{7'h70, 2'b11, 8'hE0, 1'b0};
    vecs[11] = '{7'h70, 2'b10, 8'hF0, 1'b1};

    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_mode = 2'b00; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_mode = 2'b00; bus_b.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus_a.in_ready), 1);
    check("rst_out_valid", 32'(bus_a.out_valid), 0);
    check("rst_out_data", 32'(bus_a.out_data), 0);
    check("rst_out_bit", 32'(bus_a.out_bit), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_word_cnt", 32'(cnt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      send_a(vecs[i].data, vecs[i].mode, 1'b0);
      check($sformatf("vec%0d_data", i), 32'(bus_a.out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_bit", i), 32'(bus_a.out_bit), 32'(vecs[i].exp_bit));
      finish_a();
    end

    // Mode flips every cycle while counting must not disturb the latched mode
    send_a(7'h55, 2'b10, 1'b1);
    check("toggle_data", 32'(bus_a.out_data), 32'h A5);
    finish_a();

    // Back-pressure in DONE with a competing input offer
    send_a(7'h03, 2'b00, 1'b0);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 7'h7F;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold_data", 32'(bus_a.out_data), 32'h13);
      check("hold_valid", 32'(bus_a.out_valid), 1);
      check("hold_in_ready", 32'(bus_a.in_ready), 0);
    end
    bus_a.in_valid = 1'b0;
    finish_a();
    check("no_second_word", 32'(busy_a), 0);
    repeat (2) @(posedge clk);
    #1;
    check("no_second_valid", 32'(bus_a.out_valid), 0);

    // Reset mid-COUNT discards the word
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 7'h7F;
    bus_a.in_mode  = 2'b00;
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus_a.out_valid), 0);
    check("midrst_word_cnt", 32'(cnt_a), 0);
    check("midrst_in_ready", 32'(bus_a.in_ready), 1);
    check("midrst_busy", 32'(busy_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk);
        #1;
        if (bus_a.out_valid === 1'b1) seen++;
      end
      check("midrst_no_output", 32'(seen), 0);
      check("midrst_in_ready_after", 32'(bus_a.in_ready), 1);
    end

    // 16 transfers wrap a 4-bit counter; 4/4 tie in inv-majority gives 1, bit at MSB
    for (int k = 0; k < 16; k++) begin
      int lat;
      @(negedge clk);
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = 8'h0F;
      bus_b.in_mode  = 2'b01;
      @(posedge clk);
      #1;
      bus_b.in_valid = 1'b0;
      lat = 0;
      while (bus_b.out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("b_latency", 32'(lat), 8);
      check("b_out_data", 32'(bus_b.out_data), 32'h10F);
      check("b_out_bit", 32'(bus_b.out_bit), 1);
      bus_b.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_b.out_ready = 1'b0;
      check("b_word_cnt", 32'(cnt_b), 32'((k + 1) % 16));
    end
    check("b_wrap_zero", 32'(cnt_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
